// File: rtl/uart_rx_periph_if.sv
// ---------------------------------------------------------------------------
// uart_rx_periph_if
// Load/store bus between the CPU and the UART receiver peripheral.
//   rd     : read strobe (MemRd & addr[30])
//   wr     : write strobe (MemWr & addr[30])
//   addr   : byte address from the ALU
//   wdata  : store data
//   rdata  : read data, driven combinationally by the peripheral
// The CPU side uses the master modport, the peripheral uses the slave modport.
// ---------------------------------------------------------------------------
interface uart_rx_periph_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output rd, output wr, output addr, output wdata, input rdata);
  modport slave  (input rd, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/uart_rx_periph.sv
// ---------------------------------------------------------------------------
// uart_rx_periph
// Memory-mapped UART receiver. Deserialises frames arriving on rx into a
// receive data register and exposes data, status and interrupt control on
// the CPU load/store bus.
//
// Ports:
//   clk      : system clock
//   reset    : synchronous, active-low reset
//   bus      : load/store bus (slave modport of uart_rx_periph_if);
//              rdata is combinational from addr/rd and is 0 when rd=0
//   rx       : asynchronous serial input, idle high
//   irq      : registered interrupt request, level (irq_en & valid)
//   rx_busy  : registered, high while a frame is being received
//
// Registers:
//   ADDR_DATA (read)  : {24'd0, rx_data}; a read clears valid
//   ADDR_CTRL (read)  : {valid, ferr, overrun, irq_en} in bits [3:0]
//   ADDR_CTRL (write) : bit0 -> irq_en, bit1 W1C overrun, bit2 W1C ferr
//
// Build option: define UART_RX_PARITY_EN for 8E1 frames. A parity bit is
// then sampled after the data bits; a parity error sets perr (CTRL bit4,
// W1C via bit4) and discards the byte. Without the macro frames are 8N1
// and bit4 reads 0.
// ---------------------------------------------------------------------------
module uart_rx_periph #(
  parameter int          BAUD_DIV  = 5208,
  parameter logic [31:0] ADDR_DATA = 32'h4000_001C,
  parameter logic [31:0] ADDR_CTRL = 32'h4000_0020
) (
  input  logic              clk,
  input  logic              reset,
  uart_rx_periph_if.slave   bus,
  input  logic              rx,
  output logic              irq,
  output logic              rx_busy
);

  localparam int                SYNC_STAGES = 2;
  localparam int                CNT_W       = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0]  LAST_CNT    = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0]  HALF_CNT    = CNT_W'(BAUD_DIV / 2 - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  // -------------------------------------------------------------------------
  // Input synchroniser: rx is asynchronous, the FSM only ever looks at rx_s.
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_next;
  logic                   rx_s;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sync_next[gi] = rx;
      end else begin : g_chain
        assign sync_next[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= sync_next;
    end
  end

  assign rx_s = sync_reg[SYNC_STAGES-1];

  // -------------------------------------------------------------------------
  // Receiver state
  // -------------------------------------------------------------------------
  state_t           state_reg;
  logic [CNT_W-1:0] cyc_cnt_reg;
  logic [2:0]       bit_cnt_reg;
  logic [7:0]       shift_reg;
  logic             wait_high_reg;   // line stuck low after a framing error
  logic             rx_busy_reg;
`ifdef UART_RX_PARITY_EN
  logic             par_bad_reg;     // current frame failed its parity check
`endif

  // Register file
  logic [7:0] rx_data_reg,  rx_data_next;
  logic       valid_reg,    valid_next;
  logic       overrun_reg,  overrun_next;
  logic       ferr_reg,     ferr_next;
  logic       irq_en_reg,   irq_en_next;
  logic       irq_reg;
`ifdef UART_RX_PARITY_EN
  logic       perr_reg,     perr_next;
  logic       par_fail;
`endif

  logic bit_tick;
  logic half_tick;
  logic stop_sample;
  logic byte_good;
  logic frame_err;
  logic rd_data;
  logic wr_ctrl;

  assign bit_tick    = (cyc_cnt_reg == LAST_CNT);
  assign half_tick   = (cyc_cnt_reg == HALF_CNT);
  assign stop_sample = (state_reg == ST_STOP) && bit_tick;
  assign frame_err   = stop_sample && !rx_s;
`ifdef UART_RX_PARITY_EN
  assign par_fail    = (state_reg == ST_PARITY) && bit_tick && (^{shift_reg, rx_s});
  assign byte_good   = stop_sample && rx_s && !par_bad_reg;
`else
  assign byte_good   = stop_sample && rx_s;
`endif

  assign rd_data = bus.rd && (bus.addr == ADDR_DATA);
  assign wr_ctrl = bus.wr && (bus.addr == ADDR_CTRL);

  // -------------------------------------------------------------------------
  // Frame FSM. Counters restart at every sample point so each state simply
  // waits for its own tick. rx_busy is registered alongside each transition.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      cyc_cnt_reg   <= '0;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      wait_high_reg <= 1'b0;
      rx_busy_reg   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          cyc_cnt_reg <= '0;
          bit_cnt_reg <= '0;
          if (wait_high_reg) begin
            // A low stop bit is not a start bit: wait for the line to idle.
            if (rx_s) wait_high_reg <= 1'b0;
          end else if (!rx_s) begin
            state_reg   <= ST_START;
            rx_busy_reg <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_bad_reg <= 1'b0;
`endif
          end
        end

        ST_START: begin
          if (half_tick) begin
            cyc_cnt_reg <= '0;
            if (rx_s) begin
              // Start bit did not survive to mid-bit: a glitch, no flag.
              state_reg   <= ST_IDLE;
              rx_busy_reg <= 1'b0;
            end else begin
              state_reg <= ST_DATA;
            end
          end else begin
            cyc_cnt_reg <= cyc_cnt_reg + 1'b1;
          end
        end

        ST_DATA: begin
          if (bit_tick) begin
            cyc_cnt_reg <= '0;
            shift_reg   <= {rx_s, shift_reg[7:1]};   // LSB arrives first
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_reg <= ST_PARITY;
`else
              state_reg <= ST_STOP;
`endif
            end
          end else begin
            cyc_cnt_reg <= cyc_cnt_reg + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (bit_tick) begin
            cyc_cnt_reg <= '0;
            par_bad_reg <= par_fail;
            state_reg   <= ST_STOP;
          end else begin
            cyc_cnt_reg <= cyc_cnt_reg + 1'b1;
          end
        end
`endif

        ST_STOP: begin
          if (bit_tick) begin
            cyc_cnt_reg   <= '0;
            state_reg     <= ST_IDLE;
            rx_busy_reg   <= 1'b0;
            wait_high_reg <= !rx_s;
          end else begin
            cyc_cnt_reg <= cyc_cnt_reg + 1'b1;
          end
        end

        default: begin
          state_reg   <= ST_IDLE;
          cyc_cnt_reg <= '0;
          rx_busy_reg <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Register next-state. Later assignments take priority: hardware sets
  // override W1C clears, and a completing byte overrides a read clearing valid.
  // Overrun is only raised when the unread byte is not being read this cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    rx_data_next = rx_data_reg;
    valid_next   = valid_reg;
    overrun_next = overrun_reg;
    ferr_next    = ferr_reg;
    irq_en_next  = irq_en_reg;

    if (rd_data) valid_next = 1'b0;
    if (wr_ctrl) begin
      irq_en_next = bus.wdata[0];
      if (bus.wdata[1]) overrun_next = 1'b0;
      if (bus.wdata[2]) ferr_next    = 1'b0;
    end

    if (byte_good) begin
      rx_data_next = shift_reg;
      valid_next   = 1'b1;
      if (valid_reg && !rd_data) overrun_next = 1'b1;
    end
    if (frame_err) ferr_next = 1'b1;
  end

`ifdef UART_RX_PARITY_EN
  always_comb begin
    perr_next = perr_reg;
    if (wr_ctrl && bus.wdata[4]) perr_next = 1'b0;
    if (par_fail)                perr_next = 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_data_reg <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
      ferr_reg    <= 1'b0;
      irq_en_reg  <= 1'b0;
      irq_reg     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_reg    <= 1'b0;
`endif
    end else begin
      rx_data_reg <= rx_data_next;
      valid_reg   <= valid_next;
      overrun_reg <= overrun_next;
      ferr_reg    <= ferr_next;
      irq_en_reg  <= irq_en_next;
      // Follows valid_next so irq falls together with valid after a read.
      irq_reg     <= irq_en_reg & valid_next;
`ifdef UART_RX_PARITY_EN
      perr_reg    <= perr_next;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Combinational read port
  // -------------------------------------------------------------------------
  always_comb begin
    bus.rdata = '0;
    if (bus.rd) begin
      if (bus.addr == ADDR_DATA) begin
        bus.rdata = {24'd0, rx_data_reg};
      end else if (bus.addr == ADDR_CTRL) begin
        bus.rdata[3:0] = {valid_reg, ferr_reg, overrun_reg, irq_en_reg};
`ifdef UART_RX_PARITY_EN
        bus.rdata[4]   = perr_reg;
`endif
      end
    end
  end

  // Upper store-data bits have no register behind them.
  logic unused_wdata;
`ifdef UART_RX_PARITY_EN
  assign unused_wdata = ^{bus.wdata[31:5], bus.wdata[3]};
`else
  assign unused_wdata = ^bus.wdata[31:3];
`endif

  assign irq     = irq_reg;
  assign rx_busy = rx_busy_reg;

endmodule

// File: tb/tb_uart_rx_periph.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_periph
// Bench for uart_rx_periph with BAUD_DIV=8. A vector table covers the basic
// register behaviour, hand-written sequences cover irq timing, start-bit
// glitches and mid-frame reset, and a randomized section compares the
// register map against a frame-level model of the receiver.
// ---------------------------------------------------------------------------
module tb_uart_rx_periph;

  localparam int          BAUD      = 8;
  localparam logic [31:0] A_DATA    = 32'h4000_001C;
  localparam logic [31:0] A_CTRL    = 32'h4000_0020;
`ifdef UART_RX_PARITY_EN
  localparam int          FRAME_CYC = 11 * BAUD + 4;
`else
  localparam int          FRAME_CYC = 10 * BAUD + 4;
`endif

  localparam int OP_FRAME  = 0;
  localparam int OP_RDCTRL = 1;
  localparam int OP_RDDATA = 2;
  localparam int OP_WRCTRL = 3;
  localparam int OP_RDADDR = 4;   // read at an arbitrary address
  localparam int OP_NORD   = 5;   // rd=0 with addr on CTRL

  typedef struct {
    int          op;
    logic [7:0]  data;
    logic        stop;
    logic [31:0] arg;
    logic [31:0] exp;
    string       name;
  } vec_t;

  logic clk;
  logic reset;
  logic rx;
  logic irq;
  logic rx_busy;

  uart_rx_periph_if bus_if ();

  uart_rx_periph #(
    .BAUD_DIV  (BAUD),
    .ADDR_DATA (A_DATA),
    .ADDR_CTRL (A_CTRL)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus_if),
    .rx      (rx),
    .irq     (irq),
    .rx_busy (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  // Frame-level reference state
  logic [7:0] m_data;
  logic       m_valid, m_ferr, m_ovr, m_irqen;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  task automatic add_vec(input int op, input logic [7:0] d, input logic s,
                         input logic [31:0] arg, input logic [31:0] exp, input string name);
    vec_t v;
    v.op = op; v.data = d; v.stop = s; v.arg = arg; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  // All bus/serial tasks are entered just after a falling edge.
  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BAUD) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d);
`endif
    drive_bit(stop);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus_if.rd   = 1'b1;
    bus_if.addr = a;
    #1 d = bus_if.rdata;
    @(negedge clk);
    bus_if.rd   = 1'b0;
    bus_if.addr = '0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus_if.wr    = 1'b1;
    bus_if.addr  = a;
    bus_if.wdata = d;
    @(negedge clk);
    bus_if.wr    = 1'b0;
    bus_if.addr  = '0;
    bus_if.wdata = '0;
  endtask

  function automatic logic [31:0] model_ctrl();
    return {28'd0, m_valid, m_ferr, m_ovr, m_irqen};
  endfunction

  initial begin
    logic [31:0] rv;
    logic        saw_irq;
    int          busy_cnt;

    reset = 1'b0;
    rx = 1'b1;
    bus_if.rd = 1'b0;
    bus_if.wr = 1'b0;
    bus_if.addr = '0;
    bus_if.wdata = '0;

    // ---------------- reset ----------------
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    bus_read(A_CTRL, rv);
    check("reset_ctrl", rv, 32'h0);
    check("reset_irq", {31'd0, irq}, 32'h0);
    check("reset_busy", {31'd0, rx_busy}, 32'h0);

    // ---------------- vector table ----------------
    add_vec(OP_RDCTRL, 8'h00, 1'b1, 32'h0, 32'h0,   "idle_ctrl");
    add_vec(OP_NORD,   8'h00, 1'b1, 32'h0, 32'h0,   "no_rd_zero");
    add_vec(OP_FRAME,  8'hA5, 1'b1, 32'h0, 32'h0,   "frame_a5");
    add_vec(OP_RDCTRL, 8'h00, 1'b1, 32'h0, 32'h8,   "a5_ctrl_valid");
    add_vec(OP_RDDATA, 8'h00, 1'b1, 32'h0, 32'hA5,  "a5_data");
    add_vec(OP_RDCTRL, 8'h00, 1'b1, 32'h0, 32'h0,   "a5_ctrl_cleared");
    add_vec(OP_FRAME,  8'h11, 1'b1, 32'h0, 32'h0,   "frame_11");
    add_vec(OP_FRAME,  8'h22, 1'b1, 32'h0, 32'h0,   "frame_22");
    add_vec(OP_RDCTRL, 8'h00, 1'b1, 32'h0, 32'hA,   "ovr_ctrl");
    add_vec(OP_RDDATA, 8'h00, 1'b1, 32'h0, 32'h22,  "ovr_data");
    add_vec(OP_RDCTRL, 8'h00, 1'b1, 32'h0, 32'h2,   "ovr_after_read");
    add_vec(OP_WRCTRL, 8'h00, 1'b1, 32'h2, 32'h0,   "w1c_ovr");
    add_vec(OP_RDCTRL, 8'h00, 1'b1, 32'h0, 32'h0,   "ovr_cleared");
    add_vec(OP_FRAME,  8'h5A, 1'b0, 32'h0, 32'h0,   "frame_bad_stop");
    add_vec(OP_RDCTRL, 8'h00, 1'b1, 32'h0, 32'h4,   "ferr_ctrl");
    add_vec(OP_RDDATA, 8'h00, 1'b1, 32'h0, 32'h22,  "ferr_data_kept");
    add_vec(OP_WRCTRL, 8'h00, 1'b1, 32'h4, 32'h0,   "w1c_ferr");
    add_vec(OP_RDCTRL, 8'h00, 1'b1, 32'h0, 32'h0,   "ferr_cleared");
    add_vec(OP_WRCTRL, 8'h00, 1'b1, 32'hFFFF_FFF1, 32'h0, "wr_data_ignored");
    add_vec(OP_RDADDR, 8'h00, 1'b1, A_DATA, 32'h22, "data_unchanged_by_wr");
    add_vec(OP_RDADDR, 8'h00, 1'b1, 32'h4000_0024, 32'h0, "unmapped_read");

    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_FRAME:  send_frame(vecs[i].data, vecs[i].stop);
        OP_RDCTRL: begin bus_read(A_CTRL, rv); check(vecs[i].name, rv, vecs[i].exp); end
        OP_RDDATA: begin bus_read(A_DATA, rv); check(vecs[i].name, rv, vecs[i].exp); end
        OP_RDADDR: begin bus_read(vecs[i].arg, rv); check(vecs[i].name, rv, vecs[i].exp); end
        OP_WRCTRL: begin
          if (vecs[i].name == "wr_data_ignored") bus_write(A_DATA, vecs[i].arg);
          else bus_write(A_CTRL, vecs[i].arg);
        end
        OP_NORD: begin
          bus_if.addr = A_CTRL;
          #1 check(vecs[i].name, bus_if.rdata, vecs[i].exp);
          @(negedge clk);
          bus_if.addr = '0;
        end
        default: ;
      endcase
    end

    // ---------------- irq timing ----------------
    bus_write(A_CTRL, 32'h1);
    saw_irq = 1'b0;
    fork
      send_frame(8'h3C, 1'b1);
      begin
        bus_if.rd   = 1'b1;
        bus_if.addr = A_CTRL;
        for (int k = 0; k < FRAME_CYC; k++) begin
          @(negedge clk);
          #1;
          if (irq) saw_irq = 1'b1;
          check("irq_tracks_valid", {31'd0, irq}, {31'd0, bus_if.rdata[3]});
        end
        bus_if.rd   = 1'b0;
        bus_if.addr = '0;
      end
    join
    check("irq_raised", {31'd0, saw_irq}, 32'h1);
    bus_if.rd   = 1'b1;
    bus_if.addr = A_DATA;
    #1;
    check("irq_data", bus_if.rdata, 32'h3C);
    check("irq_during_read", {31'd0, irq}, 32'h1);
    @(negedge clk);
    bus_if.rd   = 1'b0;
    bus_if.addr = '0;
    #1 check("irq_after_read", {31'd0, irq}, 32'h0);
    bus_write(A_CTRL, 32'h6);

    // ---------------- start-bit glitch ----------------
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    busy_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (rx_busy) busy_cnt++;
    end
    check("glitch_busy_cycles", busy_cnt, 32'd4);
    check("glitch_busy_end", {31'd0, rx_busy}, 32'h0);
    bus_read(A_CTRL, rv);
    check("glitch_no_flags", rv, 32'h0);

    // ---------------- randomized frames vs model ----------------
    m_data = 8'h3C; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0; m_irqen = 1'b0;
    for (int n = 0; n < 24; n++) begin
      logic [7:0]  b;
      logic        s;
      logic [31:0] w;
      b = 8'($urandom);
      s = ($urandom_range(0, 3) != 0);
      send_frame(b, s);
      if (s) begin
        if (m_valid) m_ovr = 1'b1;
        m_data  = b;
        m_valid = 1'b1;
      end else begin
        m_ferr = 1'b1;
      end
      bus_read(A_CTRL, rv);
      check("rand_ctrl", rv, model_ctrl());
      check("rand_irq", {31'd0, irq}, {31'd0, m_irqen & m_valid});
      if ($urandom_range(0, 1) == 1) begin
        bus_read(A_DATA, rv);
        check("rand_data", rv, {24'd0, m_data});
        m_valid = 1'b0;
      end
      if ($urandom_range(0, 2) == 0) begin
        w = {29'd0, 3'($urandom)};
        bus_write(A_CTRL, w);
        m_irqen = w[0];
        if (w[1]) m_ovr  = 1'b0;
        if (w[2]) m_ferr = 1'b0;
      end
    end
    @(negedge clk);
    bus_read(A_CTRL, rv);
    check("rand_final_ctrl", rv, model_ctrl());
    check("rand_final_irq", {31'd0, irq}, {31'd0, m_irqen & m_valid});

    // ---------------- reset mid-frame ----------------
    rx = 1'b0;
    repeat (3 * BAUD) @(negedge clk);
    check("midframe_busy", {31'd0, rx_busy}, 32'h1);
    reset = 1'b0;
    rx = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_busy", {31'd0, rx_busy}, 32'h0);
    check("midreset_irq", {31'd0, irq}, 32'h0);
    bus_read(A_CTRL, rv);
    check("midreset_ctrl", rv, 32'h0);
    bus_read(A_DATA, rv);
    check("midreset_data", rv, 32'h0);
    send_frame(8'h96, 1'b1);
    bus_read(A_DATA, rv);
    check("post_reset_frame", rv, 32'h96);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
